// File: rtl/regfile_bypass_scoreboard.sv
// Integer register file with NRD combinational read ports, same-cycle write bypass,
// optional hardwired zero register and a per-register busy scoreboard for RAW hazards.
module regfile_bypass_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic [AW:0]          busy_cnt
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    // An address is usable when it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic [AW:0]                busy_cnt_q, busy_cnt_d;
    logic                       wr_valid, bs_valid;

    // Gating with reset_n keeps the bypass path quiet while reset is held.
    assign wr_valid = reset_n && we && addr_ok(waddr);
    assign bs_valid = reset_n && busy_set && addr_ok(busy_addr);

    always_comb begin
        rf_d       = rf_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_valid && (waddr == AW'(i))) begin
                rf_d[i]   = wdata;
                busy_d[i] = 1'b0;
            end
            // Applied after the clear so a new producer wins over a retiring one.
            if (bs_valid && (busy_addr == AW'(i)))
                busy_d[i] = 1'b1;
        end
        for (int i = 0; i < NREGS; i++)
            busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_q       <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            rf_q       <= rf_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            hit;
        logic            busy_sel;
        logic [XLEN-1:0] rf_sel;

        assign ra = raddr[k*AW +: AW];

        always_comb begin
            rf_sel   = '0;
            busy_sel = 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                if (ra == AW'(i)) begin
                    rf_sel   = rf_q[i];
                    busy_sel = busy_q[i];
                end
            end
            hit = wr_valid && (waddr == ra);
        end

        assign rdata[k*XLEN +: XLEN] = !addr_ok(ra) ? '0 : (hit ? wdata : rf_sel);
        // A retiring write releases the hazard in the cycle it lands.
        assign rbusy[k] = busy_sel & ~hit;
    end

endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Bench for regfile_bypass_scoreboard: directed vector table, non-power-of-2 corner
// sequence, mid-cycle reset and a randomized run against a behavioural model.
module tb_regfile_bypass_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int NRD   = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // main DUT: NREGS=16, NRD=3, zero register on
    logic                we, busy_set;
    logic [AW-1:0]       waddr, busy_addr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [AW:0]         busy_cnt;

    // second DUT: NREGS=12 (out-of-range addresses exist), NRD=2, zero register off
    logic          o_we, o_bs;
    logic [3:0]    o_wa, o_ba;
    logic [31:0]   o_wd;
    logic [7:0]    o_ra;
    logic [63:0]   o_rd;
    logic [1:0]    o_rb;
    logic [4:0]    o_cnt;

    regfile_bypass_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .busy_set(busy_set),
        .busy_addr(busy_addr), .busy_cnt(busy_cnt));

    regfile_bypass_scoreboard #(.XLEN(32), .NREGS(12), .NRD(2), .ZERO_REG(0)) u_odd (
        .clk(clk), .reset_n(reset_n), .we(o_we), .waddr(o_wa), .wdata(o_wd),
        .raddr(o_ra), .rdata(o_rd), .rbusy(o_rb), .busy_set(o_bs),
        .busy_addr(o_ba), .busy_cnt(o_cnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        bs;
        logic [3:0]  ba;
        logic [11:0] ra;
        logic [95:0] exp_rd;
        logic [2:0]  exp_rb;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we_i, input logic [3:0] wa_i, input logic [31:0] wd_i,
                                input logic bs_i, input logic [3:0] ba_i,
                                input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] rb, input logic [4:0] cnt);
        vec_t v;
        v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.bs = bs_i; v.ba = ba_i;
        v.ra = {r2, r1, r0};
        v.exp_rd = {d2, d1, d0};
        v.exp_rb = rb;
        v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; busy_set = 0; busy_addr = 0; raddr = 0;
        o_we = 0; o_wa = 0; o_wd = 0; o_bs = 0; o_ba = 0; o_ra = 0;
    endtask

    task automatic ostep(input logic we_i, input logic [3:0] wa_i, input logic [31:0] wd_i,
                         input logic bs_i, input logic [3:0] ba_i,
                         input logic [3:0] r0, input logic [3:0] r1,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [1:0] eb, input logic [4:0] ecnt, input int n);
        @(negedge clk);
        o_we = we_i; o_wa = wa_i; o_wd = wd_i; o_bs = bs_i; o_ba = ba_i; o_ra = {r1, r0};
        #1;
        chk($sformatf("odd%0d rdata", n), {32'h0, o_rd}, {32'h0, e1, e0});
        chk($sformatf("odd%0d rbusy", n), {94'h0, o_rb}, {94'h0, eb});
        chk($sformatf("odd%0d busy_cnt", n), {91'h0, o_cnt}, {91'h0, ecnt});
    endtask

    // behavioural reference for the random phase
    logic [31:0] m_rf[NREGS];
    bit          m_busy[NREGS];

    initial begin
        // directed table: inputs applied, outputs checked before the clock edge
        vecs.push_back(mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(1, 5, 32'h11, 0, 0, 5, 5, 5, 32'h11, 32'h11, 32'h11, 3'b000, 0));
        vecs.push_back(mk(1, 5, 32'h22, 0, 0, 5, 5, 0, 32'h22, 32'h22, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 5, 5, 5, 32'h22, 32'h22, 32'h22, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 7, 7, 5, 0, 0, 32'h22, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 7, 5, 0, 0, 32'h22, 3'b011, 1));
        vecs.push_back(mk(1, 7, 32'h77, 0, 0, 7, 5, 7, 32'h77, 32'h22, 32'h77, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0, 32'h77, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9, 9, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(1, 9, 32'h99, 1, 9, 9, 9, 0, 32'h99, 32'h99, 0, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 9, 7, 32'h99, 32'h99, 32'h77, 3'b011, 1));
        vecs.push_back(mk(1, 9, 32'hA5, 0, 0, 9, 3, 9, 32'hA5, 0, 32'hA5, 3'b000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 3, 0, 32'hA5, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 3'b001, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 3'b001, 1));
        vecs.push_back(mk(1, 3, 32'h33, 0, 0, 3, 0, 3, 32'h33, 0, 32'h33, 3'b000, 1));
        vecs.push_back(mk(1, 15, 32'hF0, 0, 0, 3, 15, 0, 32'h33, 32'hF0, 0, 3'b000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 15, 3, 0, 32'hF0, 32'h33, 0, 3'b000, 0));

        idle();
        reset_n = 0;
        #1;
        chk("reset rdata", rdata, 96'h0);
        chk("reset busy_cnt", {91'h0, busy_cnt}, 96'h0);
        repeat (2) @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
            busy_set = vecs[i].bs; busy_addr = vecs[i].ba; raddr = vecs[i].ra;
            #1;
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
            chk($sformatf("vec%0d rbusy", i), {93'h0, rbusy}, {93'h0, vecs[i].exp_rb});
            chk($sformatf("vec%0d busy_cnt", i), {91'h0, busy_cnt}, {91'h0, vecs[i].exp_cnt});
        end
        @(negedge clk);
        idle();

        // non-power-of-2 register count with zero register disabled
        ostep(1, 0, 32'h1234, 0, 0, 0, 0, 32'h1234, 32'h1234, 2'b00, 0, 1);
        ostep(1, 13, 32'hBAD, 0, 0, 13, 0, 0, 32'h1234, 2'b00, 0, 2);
        ostep(0, 0, 0, 1, 14, 13, 0, 0, 32'h1234, 2'b00, 0, 3);
        ostep(0, 0, 0, 1, 0, 0, 13, 32'h1234, 0, 2'b00, 0, 4);
        ostep(0, 0, 0, 0, 0, 0, 0, 32'h1234, 32'h1234, 2'b11, 1, 5);
        ostep(1, 11, 32'hB0B, 0, 0, 11, 0, 32'hB0B, 32'h1234, 2'b10, 1, 6);
        ostep(1, 0, 32'h5555, 0, 0, 0, 11, 32'h5555, 32'hB0B, 2'b00, 1, 7);
        ostep(0, 0, 0, 0, 0, 0, 11, 32'h5555, 32'hB0B, 2'b00, 0, 8);
        @(negedge clk);
        idle();

        // fill registers and scoreboard, then reset in the middle of a cycle
        for (int i = 1; i < NREGS; i++) begin
            @(negedge clk);
            we = 1; waddr = AW'(i); wdata = 32'h1111 * i;
            busy_set = 1; busy_addr = AW'(i);
        end
        @(negedge clk);
        we = 1; waddr = 3; wdata = 32'hFFFF; busy_set = 1; busy_addr = 4;
        raddr = {4'd3, 4'd2, 4'd1};
        #1;
        chk("prereset busy_cnt", {91'h0, busy_cnt}, 96'd15);
        #1;
        reset_n = 0;
        #1;
        chk("midreset rdata", rdata, 96'h0);
        chk("midreset rbusy", {93'h0, rbusy}, 96'h0);
        chk("midreset busy_cnt", {91'h0, busy_cnt}, 96'h0);
        we = 0; busy_set = 0;
        #4;
        reset_n = 1;
        @(negedge clk);
        raddr = {4'd4, 4'd3, 4'd15};
        #1;
        chk("postreset rdata", rdata, 96'h0);
        chk("postreset rbusy", {93'h0, rbusy}, 96'h0);
        chk("postreset busy_cnt", {91'h0, busy_cnt}, 96'h0);

        // randomized run against the reference model (DUT is freshly reset)
        for (int i = 0; i < NREGS; i++) begin
            m_rf[i] = 0;
            m_busy[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [95:0] e_rd;
            logic [2:0]  e_rb;
            int          e_cnt;
            bit          wvalid;
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, NREGS - 1));
            wdata = $urandom;
            busy_set = ($urandom_range(0, 9) < 4);
            busy_addr = AW'($urandom_range(0, NREGS - 1));
            for (int k = 0; k < NRD; k++)
                raddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr
                                                                 : AW'($urandom_range(0, NREGS - 1));
            #1;
            wvalid = we && (waddr != 0);
            e_cnt = 0;
            for (int i = 0; i < NREGS; i++)
                e_cnt += int'(m_busy[i]);
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(raddr[k*AW +: AW]);
                if (a == 0)
                    e_rd[k*32 +: 32] = 0;
                else if (wvalid && int'(waddr) == a)
                    e_rd[k*32 +: 32] = wdata;
                else
                    e_rd[k*32 +: 32] = m_rf[a];
                e_rb[k] = m_busy[a] && !(wvalid && int'(waddr) == a);
            end
            chk($sformatf("rand%0d rdata", cyc), rdata, e_rd);
            chk($sformatf("rand%0d rbusy", cyc), {93'h0, rbusy}, {93'h0, e_rb});
            chk($sformatf("rand%0d busy_cnt", cyc), {91'h0, busy_cnt}, 96'(e_cnt));
            if (wvalid) begin
                m_rf[waddr] = wdata;
                m_busy[waddr] = 0;
            end
            if (busy_set && busy_addr != 0)
                m_busy[busy_addr] = 1;
        end
        @(negedge clk);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
